// File: rtl/express_sel_arbiter.sv
// rtl/express_sel_arbiter.sv - round-robin arbiter sharing the express select datapath
//
// Purpose:
//   Grants one of NREQ requesters at a time access to the shared combinational
//   select datapath. It drives the winner's select code on o_express with
//   o_dp_en high for LAT cycles, captures i_dp_result, and returns it on a
//   valid/ready response channel tagged with the requester index.
//
// Ports:
//   i_clk         clock, all logic on rising edge
//   i_rst         synchronous active-high reset
//   i_req         request per requester, held until granted
//   i_sel_flat    select code per requester, requester i at [i*SEL_W +: SEL_W]
//   o_gnt         one-hot, one-cycle grant pulse
//   o_express     select code to the shared datapath
//   o_dp_en       high while o_express is valid for the datapath
//   i_dp_result   combinational datapath result
//   o_rsp_valid   response valid
//   o_rsp_id      index of granted requester
//   o_rsp_data    captured datapath result
//   i_rsp_ready   response consumer ready
//   o_busy        high whenever the arbiter is not idle

module express_sel_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int SEL_W = 4,
  parameter int DAT_W = 16,
  parameter int LAT   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*SEL_W-1:0]   i_sel_flat,
  output logic [NREQ-1:0]         o_gnt,
  output logic [SEL_W-1:0]        o_express,
  output logic                    o_dp_en,
  input  logic [DAT_W-1:0]        i_dp_result,
  output logic                    o_rsp_valid,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [DAT_W-1:0]        o_rsp_data,
  input  logic                    i_rsp_ready,
  output logic                    o_busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [NREQ-1:0]    r_gnt;
  logic [SEL_W-1:0]   r_express;
  logic               r_dp_en;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [DAT_W-1:0]   r_rsp_data;
  logic               r_busy;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic [NREQ-1:0]    w_gnt_nxt;
  logic [SEL_W-1:0]   w_express_nxt;
  logic               w_dp_en_nxt;
  logic               w_rsp_valid_nxt;
  logic [ID_W-1:0]    w_rsp_id_nxt;
  logic [DAT_W-1:0]   w_rsp_data_nxt;
  logic               w_busy_nxt;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Round-robin winner search
  logic [NREQ-1:0]    w_req_rot;
  logic [ID_W:0]      w_off;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_win;
  logic               w_found;

  // Rotate requests so that bit 0 is the requester at r_ptr; the lowest set
  // bit of the rotated vector is then the offset of the winner from r_ptr.
  always_comb begin
    w_req_rot = NREQ'({i_req, i_req} >> r_ptr);
    w_found   = |i_req;
    w_off     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_off = (ID_W+1)'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + w_off;
    if (w_sum >= (ID_W+1)'(NREQ)) begin
      w_sum = w_sum - (ID_W+1)'(NREQ);
    end
    w_win = w_sum[ID_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_express   <= '0;
      r_dp_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_express   <= w_express_nxt;
      r_dp_en     <= w_dp_en_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_busy      <= w_busy_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = '0;
    w_express_nxt   = r_express;
    w_dp_en_nxt     = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt     = NREQ'(1) << w_win;
          w_express_nxt = i_sel_flat[w_win*SEL_W +: SEL_W];
          w_rsp_id_nxt  = w_win;
          w_cnt_nxt     = CNT_W'(LAT);
          w_dp_en_nxt   = 1'b1;
          w_state_nxt   = S_WAIT;
        end
      end

      S_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        // Last settle cycle: sample the datapath and drop dp_en together.
        if (r_cnt == CNT_W'(1)) begin
          w_rsp_data_nxt  = i_dp_result;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_dp_en_nxt = 1'b1;
        end
      end

      S_RESP: begin
        // Pointer only moves on completion so a backpressured winner's
        // successor keeps its turn.
        if (i_rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_ptr_nxt       = (r_rsp_id == ID_W'(NREQ - 1)) ? '0 : r_rsp_id + ID_W'(1);
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign o_gnt       = r_gnt;
  assign o_express   = r_express;
  assign o_dp_en     = r_dp_en;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_express_sel_arbiter.sv
// tb/tb_express_sel_arbiter.sv - self-checking bench for express_sel_arbiter

module tb_express_sel_arbiter;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int SEL_W = 4;
  localparam int DAT_W = 16;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int LAT_C = 4;

  if (LAT_A < 1 || LAT_A > 15 || LAT_B < 1 || LAT_B > 15 || LAT_C < 1 || LAT_C > 15) begin : g_lat_bad
    initial $fatal(1, "illegal LAT parameter");
  end

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*SEL_W-1:0] sel_flat;
  logic [DAT_W-1:0]      dp;
  logic                  rdy;

  logic [NREQ-1:0]  gnt1, gnt3, gnt4;
  logic [SEL_W-1:0] ex1, ex3, ex4;
  logic             en1, en3, en4;
  logic             v1, v3, v4;
  logic [ID_W-1:0]  id1, id3, id4;
  logic [DAT_W-1:0] d1, d3, d4;
  logic             b1, b3, b4;

  express_sel_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .SEL_W(SEL_W), .DAT_W(DAT_W), .LAT(LAT_A)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_sel_flat(sel_flat), .o_gnt(gnt1),
    .o_express(ex1), .o_dp_en(en1), .i_dp_result(dp), .o_rsp_valid(v1), .o_rsp_id(id1),
    .o_rsp_data(d1), .i_rsp_ready(rdy), .o_busy(b1));

  express_sel_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .SEL_W(SEL_W), .DAT_W(DAT_W), .LAT(LAT_B)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_sel_flat(sel_flat), .o_gnt(gnt3),
    .o_express(ex3), .o_dp_en(en3), .i_dp_result(dp), .o_rsp_valid(v3), .o_rsp_id(id3),
    .o_rsp_data(d3), .i_rsp_ready(rdy), .o_busy(b3));

  express_sel_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .SEL_W(SEL_W), .DAT_W(DAT_W), .LAT(LAT_C)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_sel_flat(sel_flat), .o_gnt(gnt4),
    .o_express(ex4), .o_dp_en(en4), .i_dp_result(dp), .o_rsp_valid(v4), .o_rsp_id(id4),
    .o_rsp_data(d4), .i_rsp_ready(rdy), .o_busy(b4));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] dp;
    logic        rdy;
    logic [3:0]  gnt;
    logic        en;
    logic [3:0]  ex;
    logic        v;
    logic [1:0]  id;
    logic [15:0] d;
    logic        b;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int which, output int idx);
    logic [3:0] g;
    idx = -1;
    for (int i = 0; i < 20 && idx < 0; i++) begin
      step();
      g = (which == 1) ? gnt1 : ((which == 3) ? gnt3 : gnt4);
      for (int j = 0; j < NREQ; j++) begin
        if (g[j]) idx = j;
      end
    end
    if (idx < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_gnt_dut%0d: no grant within 20 cycles", which);
    end
  endtask

  task automatic wait_valid(input int which);
    logic v;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      v = (which == 1) ? v1 : ((which == 3) ? v3 : v4);
      if (v) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_valid_dut%0d: no response within 20 cycles", which);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int last;
    int order [10];
    bit any_v;

    rst      = 1'b1;
    req      = '0;
    sel_flat = 16'h7531;  // requester i selects 2*i+1
    dp       = '0;
    rdy      = 1'b1;

    // Reset and single-request vectors on the LAT=1 instance
    //             rst   req    dp        rdy   gnt   en    ex    v     id    d         b
    tbl[0] = '{1'b1, 4'hF, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 4'hF, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 4'hF, 16'h0000, 1'b1, 4'h1, 1'b1, 4'h1, 1'b0, 2'd0, 16'h0000, 1'b1};
    tbl[3] = '{1'b0, 4'hF, 16'h1234, 1'b1, 4'h0, 1'b0, 4'h1, 1'b1, 2'd0, 16'h1234, 1'b1};
    tbl[4] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 2'd0, 16'h1234, 1'b0};
    tbl[5] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 2'd0, 16'h1234, 1'b0};
    tbl[6] = '{1'b0, 4'h4, 16'h0000, 1'b1, 4'h4, 1'b1, 4'h5, 1'b0, 2'd2, 16'h1234, 1'b1};
    tbl[7] = '{1'b0, 4'h4, 16'h00A5, 1'b1, 4'h0, 1'b0, 4'h5, 1'b1, 2'd2, 16'h00A5, 1'b1};
    tbl[8] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 4'h5, 1'b0, 2'd2, 16'h00A5, 1'b0};

    for (int r = 0; r < 9; r++) begin
      rst = tbl[r].rst;
      req = tbl[r].req;
      dp  = tbl[r].dp;
      rdy = tbl[r].rdy;
      step();
      check($sformatf("row%0d_gnt", r),     gnt1, tbl[r].gnt);
      check($sformatf("row%0d_dp_en", r),   en1,  tbl[r].en);
      check($sformatf("row%0d_express", r), ex1,  tbl[r].ex);
      check($sformatf("row%0d_valid", r),   v1,   tbl[r].v);
      check($sformatf("row%0d_id", r),      id1,  tbl[r].id);
      check($sformatf("row%0d_data", r),    d1,   tbl[r].d);
      check($sformatf("row%0d_busy", r),    b1,   tbl[r].b);
    end

    // Round-robin order and period, then with requester 1 withdrawn
    order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
    do_reset();
    req  = 4'hF;
    rdy  = 1'b1;
    last = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) req = 4'b1101;
      wait_gnt(1, idx);
      check($sformatf("rr_order%0d", k), idx, order[k]);
      if (k > 0) check($sformatf("rr_period%0d", k), cyc - last, 3);
      last = cyc;
    end

    // Backpressure holds the response and blocks arbitration
    do_reset();
    req = 4'hF;
    rdy = 1'b0;
    dp  = 16'hBEEF;
    wait_gnt(1, idx);
    check("bp_first_gnt", idx, 0);
    step();
    check("bp_valid", v1, 1);
    check("bp_data", d1, 16'hBEEF);
    dp = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_hold_valid%0d", k), v1, 1);
      check($sformatf("bp_hold_data%0d", k), d1, 16'hBEEF);
      check($sformatf("bp_hold_id%0d", k), id1, 0);
      check($sformatf("bp_hold_express%0d", k), ex1, 4'h1);
      check($sformatf("bp_hold_gnt%0d", k), gnt1, 0);
      check($sformatf("bp_hold_dp_en%0d", k), en1, 0);
    end
    rdy = 1'b1;
    step();
    check("bp_release_valid", v1, 0);
    step();
    check("bp_next_gnt", gnt1, 4'b0010);
    check("bp_next_express", ex1, 4'h3);

    // LAT=3 settle window and sample point
    do_reset();
    check("lat3_idle_dp_en", en3, 0);
    rdy = 1'b1;
    req = 4'b0001;
    dp  = 16'd0;
    step();
    check("lat3_gnt", gnt3, 4'b0001);
    check("lat3_dp_en_c1", en3, 1);
    req = '0;
    dp  = 16'd1;
    step();
    check("lat3_dp_en_c2", en3, 1);
    check("lat3_valid_c2", v3, 0);
    dp = 16'd2;
    step();
    check("lat3_dp_en_c3", en3, 1);
    check("lat3_valid_c3", v3, 0);
    dp = 16'd3;
    step();
    check("lat3_dp_en_c4", en3, 0);
    check("lat3_valid_c4", v3, 1);
    check("lat3_data", d3, 16'd3);
    dp = 16'd4;
    step();
    check("lat3_valid_c5", v3, 0);
    check("lat3_busy_c5", b3, 0);
    check("lat3_data_c5", d3, 16'd3);

    // Reset mid-WAIT on LAT=4 discards the transaction and clears ptr
    do_reset();
    rdy = 1'b1;
    req = 4'b0001;
    wait_gnt(4, idx);
    check("rw_pre_gnt", idx, 0);
    req = '0;
    wait_valid(4);
    step();
    check("rw_pre_idle", b4, 0);
    req = 4'b0010;
    wait_gnt(4, idx);
    check("rw_gnt1", idx, 1);
    req = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rw_busy", b4, 0);
    check("rw_dp_en", en4, 0);
    check("rw_valid", v4, 0);
    check("rw_express", ex4, 0);
    any_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (v4) any_v = 1'b1;
    end
    check("rw_no_response", any_v, 0);
    req = 4'b0011;
    wait_gnt(4, idx);
    check("rw_ptr_reset_gnt", idx, 0);
    req = 4'b0010;
    dp  = 16'h5A5A;
    wait_valid(4);
    step();
    wait_gnt(4, idx);
    check("rw_after_gnt", idx, 1);
    check("rw_after_express", ex4, 4'h3);
    req = '0;
    wait_valid(4);
    check("rw_after_id", id4, 1);
    check("rw_after_data", d4, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
